// File: rtl/ee354_project_body_scan.sv
// Snake body scanner: walks the body buffer tail->head and publishes a
// grid occupancy bitmap atomically when the walk completes.
//
// Ports
//   Clk, Reset        : clock, async active-high reset
//   Start             : single-cycle scan request (ignored while busy)
//   Head_Ptr/Tail_Ptr : buffer indices, latched on an accepted Start
//   Rd_En/Rd_Addr     : synchronous read port toward the body buffer
//   Rd_Data           : {X[7:4], Y[3:0]}, valid the cycle after Rd_En
//   Busy, Done        : scan in progress / one-cycle publish pulse
//   Cell_Snake_Vector : published bitmap, bit X*GRID+Y
//   Seg_Count         : valid entries in the last scan
//   Err               : sticky bad pointer / bad entry flag
//   Collide           : head cell already occupied by a body entry
//
// Optional feature macro: SNAKE_SCAN_COLLIDE_EN builds the head collision
// detector; without it Collide is tied low.
module ee354_project_body_scan #(
  parameter int DEPTH = 225,
  parameter int GRID  = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [7:0]       Head_Ptr,
  input  logic [7:0]       Tail_Ptr,
  output logic             Rd_En,
  output logic [7:0]       Rd_Addr,
  input  logic [7:0]       Rd_Data,
  output logic             Busy,
  output logic             Done,
  output logic [DEPTH-1:0] Cell_Snake_Vector,
  output logic [7:0]       Seg_Count,
  output logic             Err,
  output logic             Collide
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_PUBLISH
  } state_t;

  localparam logic [7:0] LP_DEPTH = 8'(DEPTH);
  localparam logic [7:0] LP_LAST  = 8'(DEPTH - 1);
  localparam logic [7:0] LP_GRID  = 8'(GRID);
  localparam logic [3:0] LP_GMAX  = 4'(GRID - 1);
  localparam logic [8:0] LP_DEP9  = 9'(DEPTH);

  state_t             r_state;
  logic [DEPTH-1:0]   r_shadow;
  logic [7:0]         r_cnt;
  logic [7:0]         r_rem;
  logic               r_cap;

  logic               w_ptr_bad;
  logic [8:0]         w_diff;
  logic [7:0]         w_span;
  logic [3:0]         w_x;
  logic [3:0]         w_y;
  logic               w_ent_ok;
  logic [7:0]         w_idx;
  logic [7:0]         w_next;

  assign w_ptr_bad = (Head_Ptr >= LP_DEPTH) ||
                     (Tail_Ptr >= LP_DEPTH);

  // L-1 = (Head - Tail) mod DEPTH, folded with one compare-and-subtract
  assign w_diff = {1'b0, Head_Ptr} + LP_DEP9
                - {1'b0, Tail_Ptr};
  assign w_span = (w_diff >= LP_DEP9) ?
                  8'(w_diff - LP_DEP9) : w_diff[7:0];

  assign w_x      = Rd_Data[7:4];
  assign w_y      = Rd_Data[3:0];
  assign w_ent_ok = (Rd_Data != 8'hFF) &&
                    (w_x <= LP_GMAX) &&
                    (w_y <= LP_GMAX);
  assign w_idx    = 8'({4'd0, w_x} * LP_GRID)
                  + {4'd0, w_y};

  assign w_next = (Rd_Addr == LP_LAST) ?
                  8'd0 : Rd_Addr + 8'd1;

  assign Busy = (r_state != S_IDLE);

`ifdef SNAKE_SCAN_COLLIDE_EN
  // Hit flag of the most recent capture; the head is captured last,
  // so at publish time this says whether the head cell was already set.
  logic r_hit;
`else
  assign Collide = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state           <= S_IDLE;
      Rd_En             <= 1'b0;
      Rd_Addr           <= 8'd0;
      Done              <= 1'b0;
      Err               <= 1'b0;
      Seg_Count         <= 8'd0;
      Cell_Snake_Vector <= '0;
      r_shadow          <= '0;
      r_cnt             <= 8'd0;
      r_rem             <= 8'd0;
      r_cap             <= 1'b0;
`ifdef SNAKE_SCAN_COLLIDE_EN
      r_hit             <= 1'b0;
      Collide           <= 1'b0;
`endif
    end else begin
      Done  <= 1'b0;
      // data for a read issued last cycle is on Rd_Data now
      r_cap <= Rd_En;
      if (r_cap) begin
        if (w_ent_ok) begin
          r_shadow[w_idx] <= 1'b1;
          r_cnt           <= r_cnt + 8'd1;
        end else begin
          Err <= 1'b1;
        end
`ifdef SNAKE_SCAN_COLLIDE_EN
        r_hit <= w_ent_ok && r_shadow[w_idx];
`endif
      end
      unique case (r_state)
        S_IDLE: begin
          // a Start coinciding with the Done pulse belongs to PUBLISH
          if (Start && !Done) begin
            r_shadow <= '0;
            r_cnt    <= 8'd0;
`ifdef SNAKE_SCAN_COLLIDE_EN
            r_hit    <= 1'b0;
`endif
            if (w_ptr_bad) begin
              Err     <= 1'b1;
              r_state <= S_DRAIN;
            end else begin
              Err     <= 1'b0;
              Rd_En   <= 1'b1;
              Rd_Addr <= Tail_Ptr;
              r_rem   <= w_span;
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (r_rem == 8'd0) begin
            Rd_En   <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            Rd_Addr <= w_next;
            r_rem   <= r_rem - 8'd1;
          end
        end
        S_DRAIN: begin
          r_state <= S_PUBLISH;
        end
        S_PUBLISH: begin
          Cell_Snake_Vector <= r_shadow;
          Seg_Count         <= r_cnt;
          Done              <= 1'b1;
`ifdef SNAKE_SCAN_COLLIDE_EN
          Collide           <= r_hit;
`endif
          r_state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule
